// File: rtl/dmi_jtag_dr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmi_jtag_dr_ctrl
// Brief    : TCK-domain DTMCS/DMI data registers and DMI request sequencer.
//            Optional: DMI_JTAG_DR_RESP_ERR_EN makes failed DM responses sticky.
// Revision : 1.0
// ============================================================================
module dmi_jtag_dr_ctrl #(
  parameter int unsigned AbitsWidth = 7,
  parameter logic [2:0]  IdleHint   = 3'd1
) (
  input  logic                  tck_i,
  input  logic                  trst_ni,
  input  logic                  dmi_clear_i,
  input  logic                  capture_i,
  input  logic                  shift_i,
  input  logic                  update_i,
  input  logic                  tdi_i,
  input  logic                  dtmcs_select_i,
  output logic                  dtmcs_tdo_o,
  input  logic                  dmi_select_i,
  output logic                  dmi_tdo_o,
  output logic                  dmi_req_valid_o,
  input  logic                  dmi_req_ready_i,
  output logic [AbitsWidth-1:0] dmi_req_addr_o,
  output logic [1:0]            dmi_req_op_o,
  output logic [31:0]           dmi_req_data_o,
  input  logic                  dmi_resp_valid_i,
  output logic                  dmi_resp_ready_o,
  input  logic [31:0]           dmi_resp_data_i,
  input  logic                  dmi_resp_err_i,
  output logic                  dmi_rst_no
);

  localparam int unsigned DrWidth = AbitsWidth + 34;

  typedef enum logic [2:0] {
    Idle      = 3'd0,
    Read      = 3'd1,
    WaitRead  = 3'd2,
    Write     = 3'd3,
    WaitWrite = 3'd4
  } state_e;

  state_e                state_q,   state_d;
  logic [1:0]            error_q,   error_d;
  logic [AbitsWidth-1:0] address_q, address_d;
  logic [31:0]           data_q,    data_d;
  logic [31:0]           dtmcs_q,   dtmcs_d;
  logic [DrWidth-1:0]    dmi_q,     dmi_d;
  logic                  rst_n_q,   rst_n_d;

  logic                  busy;
  logic                  resp_err;
  logic [31:0]           dtmcs_capture;
  logic [DrWidth-1:0]    dmi_capture;

  assign busy = (state_q != Idle);

`ifdef DMI_JTAG_DR_RESP_ERR_EN
  assign resp_err = dmi_resp_err_i;
`else
  logic unused_resp_err;
  assign resp_err        = 1'b0;
  assign unused_resp_err = dmi_resp_err_i;
`endif

  // Only the reset request bits of DTMCS are writable.
  logic unused_dtmcs;
  assign unused_dtmcs = ^{dtmcs_q[31:18], dtmcs_q[15:1]};

  assign dtmcs_capture = {14'd0, 1'b0, 1'b0, 1'b0, IdleHint, error_q,
                          6'(AbitsWidth), 4'd1};
  assign dmi_capture   = {address_q, data_q, (busy ? 2'd3 : error_q)};

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      state_q   <= Idle;
      error_q   <= 2'd0;
      address_q <= '0;
      data_q    <= '0;
      dtmcs_q   <= '0;
      dmi_q     <= '0;
      rst_n_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      error_q   <= error_d;
      address_q <= address_d;
      data_q    <= data_d;
      dtmcs_q   <= dtmcs_d;
      dmi_q     <= dmi_d;
      rst_n_q   <= rst_n_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    error_d   = error_q;
    address_d = address_q;
    data_d    = data_q;
    dtmcs_d   = dtmcs_q;
    dmi_d     = dmi_q;
    rst_n_d   = 1'b1;

    unique case (state_q)
      Read: begin
        if (dmi_req_ready_i) state_d = WaitRead;
      end
      Write: begin
        if (dmi_req_ready_i) state_d = WaitWrite;
      end
      WaitRead: begin
        if (dmi_resp_valid_i) begin
          state_d = Idle;
          if (resp_err) error_d = 2'd2;
          else          data_d  = dmi_resp_data_i;
        end
      end
      WaitWrite: begin
        if (dmi_resp_valid_i) begin
          state_d = Idle;
          if (resp_err) error_d = 2'd2;
        end
      end
      default: state_d = Idle;
    endcase

    if (dmi_select_i) begin
      if (capture_i) begin
        dmi_d = dmi_capture;
        if (busy) error_d = 2'd3;
      end else if (shift_i) begin
        dmi_d = {tdi_i, dmi_q[DrWidth-1:1]};
      end else if (update_i && (error_q == 2'd0)) begin
        // An overlapping request is dropped and flagged busy.
        if (busy) begin
          error_d = 2'd3;
        end else begin
          address_d = dmi_q[DrWidth-1:34];
          data_d    = dmi_q[33:2];
          case (dmi_q[1:0])
            2'd1:    state_d = Read;
            2'd2:    state_d = Write;
            default: state_d = Idle;
          endcase
        end
      end
    end

    if (dtmcs_select_i) begin
      if (capture_i) begin
        dtmcs_d = dtmcs_capture;
      end else if (shift_i) begin
        dtmcs_d = {tdi_i, dtmcs_q[31:1]};
      end else if (update_i) begin
        if (dtmcs_q[17]) begin
          state_d = Idle;
          error_d = 2'd0;
          rst_n_d = 1'b0;
        end else if (dtmcs_q[16]) begin
          error_d = 2'd0;
        end
      end
    end

    if (dmi_clear_i) begin
      state_d   = Idle;
      error_d   = 2'd0;
      address_d = '0;
      data_d    = '0;
      dtmcs_d   = '0;
      dmi_d     = '0;
      rst_n_d   = 1'b1;
    end
  end

  assign dtmcs_tdo_o      = dtmcs_q[0];
  assign dmi_tdo_o        = dmi_q[0];
  assign dmi_req_valid_o  = (state_q == Read) || (state_q == Write);
  assign dmi_resp_ready_o = (state_q == WaitRead) || (state_q == WaitWrite);
  assign dmi_req_addr_o   = address_q;
  assign dmi_req_data_o   = data_q;
  assign dmi_req_op_o     = (state_q == Read)  ? 2'd1 :
                            (state_q == Write) ? 2'd2 : 2'd0;
  assign dmi_rst_no       = rst_n_q;

endmodule
`default_nettype wire
